fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/cpu_fetch_pkg.sv | 26 ++
 rtl/fetch_buf.sv | 59 +++++
 rtl/fetch_pc_unit.sv | 133 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage definitions: EX-stage misprediction encodings, fetch FSM states,
// default reset PC and the redirect target helper.
package cpu_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // EX-stage resolution encodings carried on wrong_predicted_i
  localparam logic [1:0] WP_NONE      = 2'b00;
  localparam logic [1:0] WP_NOT_TAKEN = 2'b01;
  localparam logic [1:0] WP_TAKEN     = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrop
  } fetch_state_e;

  // Bit 1 alone selects the ALU target, so encoding 11 behaves as WP_TAKEN.
  function automatic logic [31:0] redirect_target(input logic [1:0]  wp,
                                                  input logic [31:0] alu_pc,
                                                  input logic [31:0] pc_ex);
    return wp[1] ? alu_pc : (pc_ex + 32'd4);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry valid/ready holding register between instruction memory and decode.
// A flush empties the entry and wins over a simultaneous load.
module fetch_buf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic        hit_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        hit_o
);

  logic        valid_d, valid_q;
  logic [31:0] inst_d, inst_q;
  logic [31:0] pc_d, pc_q;
  logic        hit_d, hit_q;

  // Next-state for the occupancy flag and payload
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    hit_d   = hit_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      inst_d  = inst_i;
      pc_d    = pc_i;
      hit_d   = hit_i;
    end
    if (flush_i) valid_d = 1'b0;
  end

  // Entry registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      inst_q  <= 32'h0;
      pc_q    <= 32'h0;
      hit_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      hit_q   <= hit_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign hit_o   = hit_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with a single-outstanding instruction memory request and a
// one-entry decode buffer. Define FETCH_BP_EN to follow branch predictor hits;
// otherwise the PC advances sequentially and id_hit_o stays 0.
module fetch_pc_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] pc_o,
  input  logic        hit_i,
  input  logic [31:0] predicted_pc_i,
  input  logic [1:0]  wrong_predicted_i,
  input  logic [31:0] alu_pc_i,
  input  logic [31:0] pc_ex_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  output logic        id_hit_o
);

`ifdef FETCH_BP_EN
  localparam bit BpEn = 1'b1;
`else
  localparam bit BpEn = 1'b0;
`endif

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  pc_cap_d, pc_cap_q;
  logic         hit_cap_d, hit_cap_q;

  logic         redirect;
  logic [31:0]  redir_pc;
  logic         grant_hit;
  logic [31:0]  next_pc;
  logic         can_issue;
  logic         buf_load;

  assign redirect  = (wrong_predicted_i != WP_NONE);
  assign redir_pc  = redirect_target(wrong_predicted_i, alu_pc_i, pc_ex_i);
  assign grant_hit = BpEn && hit_i;
  assign next_pc   = grant_hit ? predicted_pc_i : (pc_q + 32'd4);
  // Space for a new response exists once the buffer is empty or draining now
  assign can_issue = !id_valid_o || id_ready_i;

  // Fetch FSM next-state; a redirect overrides stall, issue and prediction
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_cap_d  = pc_cap_q;
    hit_cap_d = hit_cap_q;
    buf_load  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = StReq;
        end else if (can_issue) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = imem_gnt_i ? StDrop : StReq;
        end else if (imem_gnt_i) begin
          pc_cap_d  = pc_q;
          hit_cap_d = grant_hit;
          pc_d      = next_pc;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = imem_rvalid_i ? StReq : StDrop;
        end else if (imem_rvalid_i) begin
          buf_load = 1'b1;
          state_d  = StIdle;
        end
      end
      StDrop: begin
        if (redirect) pc_d = redir_pc;
        if (imem_rvalid_i) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
    if (redirect) hit_cap_d = 1'b0;
  end

  // Fetch state and PC registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      pc_cap_q  <= 32'h0;
      hit_cap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_cap_q  <= pc_cap_d;
      hit_cap_q <= hit_cap_d;
    end
  end

  assign pc_o        = pc_q;
  assign imem_req_o  = (state_q == StReq);
  assign imem_addr_o = pc_q;

  fetch_buf u_fetch_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect),
    .load_i  (buf_load),
    .inst_i  (imem_rdata_i),
    .pc_i    (pc_cap_q),
    .hit_i   (hit_cap_q),
    .valid_o (id_valid_o),
    .ready_i (id_ready_i),
    .inst_o  (id_inst_o),
    .pc_o    (id_pc_o),
    .hit_o   (id_hit_o)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; honours FETCH_BP_EN for predictor expectations.
module tb_fetch_pc_unit;

`ifdef FETCH_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] pc_o;
  logic        hit_i;
  logic [31:0] predicted_pc_i;
  logic [1:0]  wrong_predicted_i;
  logic [31:0] alu_pc_i;
  logic [31:0] pc_ex_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic        id_hit_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  fetch_pc_unit dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .pc_o              (pc_o),
    .hit_i             (hit_i),
    .predicted_pc_i    (predicted_pc_i),
    .wrong_predicted_i (wrong_predicted_i),
    .alu_pc_i          (alu_pc_i),
    .pc_ex_i           (pc_ex_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_gnt_i        (imem_gnt_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .id_valid_o        (id_valid_o),
    .id_ready_i        (id_ready_i),
    .id_inst_o         (id_inst_o),
    .id_pc_o           (id_pc_o),
    .id_hit_o          (id_hit_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Starts in REQ at exp_addr; grant now, response one cycle later; leaves buffer full.
  task automatic fetch_one(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] exp_next, input logic [31:0] data,
                           input logic hit, input logic [31:0] pred, input logic exp_hit);
    chk({tag, "_req"}, {31'h0, imem_req_o}, 32'h1);
    chk({tag, "_addr"}, imem_addr_o, exp_addr);
    imem_gnt_i = 1'b1; hit_i = hit; predicted_pc_i = pred;
    step();
    imem_gnt_i = 1'b0; hit_i = 1'b0; predicted_pc_i = 32'h0;
    chk({tag, "_next_pc"}, pc_o, exp_next);
    imem_rvalid_i = 1'b1; imem_rdata_i = data;
    step();
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    chk({tag, "_id_valid"}, {31'h0, id_valid_o}, 32'h1);
    chk({tag, "_id_pc"}, id_pc_o, exp_addr);
    chk({tag, "_id_inst"}, id_inst_o, data);
    chk({tag, "_id_hit"}, {31'h0, id_hit_o}, {31'h0, exp_hit});
  endtask

  task automatic consume();
    id_ready_i = 1'b1;
    step();
    id_ready_i = 1'b0;
  endtask

  task automatic redirect(input logic [1:0] wp, input logic [31:0] alu, input logic [31:0] pex);
    wrong_predicted_i = wp; alu_pc_i = alu; pc_ex_i = pex;
    step();
    wrong_predicted_i = 2'b00; alu_pc_i = 32'h0; pc_ex_i = 32'h0;
  endtask

  initial begin
    rst_ni = 1'b0;
    hit_i = 1'b0; predicted_pc_i = 32'h0; wrong_predicted_i = 2'b00;
    alu_pc_i = 32'h0; pc_ex_i = 32'h0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0; id_ready_i = 1'b0;
    step();
    step();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_req", {31'h0, imem_req_o}, 32'h0);
    chk("rst_valid", {31'h0, id_valid_o}, 32'h0);
    chk("rst_hit", {31'h0, id_hit_o}, 32'h0);
    chk("rst_inst", id_inst_o, 32'h0);
    chk("rst_id_pc", id_pc_o, 32'h0);

    rst_ni = 1'b1;
    step();
    fetch_one("first", 32'h0, 32'h4, 32'h0000_00A0, 1'b0, 32'h0, 1'b0);

    // Decode stalled: one buffered word, no further requests
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req", {31'h0, imem_req_o}, 32'h0);
      chk("stall_valid", {31'h0, id_valid_o}, 32'h1);
      chk("stall_id_pc", id_pc_o, 32'h0);
    end
    consume();
    chk("resume_valid", {31'h0, id_valid_o}, 32'h0);
    fetch_one("second", 32'h4, 32'h8, 32'h0000_00B4, 1'b0, 32'h0, 1'b0);
    consume();

    // Redirect in REQ without grant re-requests the new PC
    redirect(2'b10, 32'h20, 32'h0);
    chk("redir_req_still", {31'h0, imem_req_o}, 32'h1);
    chk("redir_req_addr", imem_addr_o, 32'h20);

    fetch_one("bp", 32'h20, BP ? 32'h100 : 32'h24, 32'h0000_0C20, 1'b1, 32'h100, BP);
    consume();
    chk("bp_next_addr", imem_addr_o, BP ? 32'h100 : 32'h24);

    // Redirect in WAIT without rvalid: drop the late response
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    redirect(2'b01, 32'h0, 32'h40);
    chk("drop_req", {31'h0, imem_req_o}, 32'h0);
    chk("drop_pc", pc_o, 32'h44);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    step();
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    chk("drop_no_valid", {31'h0, id_valid_o}, 32'h0);
    chk("drop_next_req", {31'h0, imem_req_o}, 32'h1);
    chk("drop_next_addr", imem_addr_o, 32'h44);

    // Redirect coinciding with rvalid discards that response
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_2222;
    redirect(2'b10, 32'h300, 32'h0);
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    chk("rv_redir_valid", {31'h0, id_valid_o}, 32'h0);
    chk("rv_redir_addr", imem_addr_o, 32'h300);

    // Redirect with grant in REQ enters DROP
    imem_gnt_i = 1'b1;
    redirect(2'b01, 32'h0, 32'h1000);
    imem_gnt_i = 1'b0;
    chk("gnt_redir_req", {31'h0, imem_req_o}, 32'h0);
    chk("gnt_redir_pc", pc_o, 32'h1004);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3333_4444;
    step();
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    chk("gnt_redir_valid", {31'h0, id_valid_o}, 32'h0);
    chk("gnt_redir_addr", imem_addr_o, 32'h1004);

    // Redirect clears a full, stalled buffer
    fetch_one("full", 32'h1004, 32'h1008, 32'h0000_0F00, 1'b0, 32'h0, 1'b0);
    redirect(2'b10, 32'h200, 32'h0);
    chk("flush_valid", {31'h0, id_valid_o}, 32'h0);
    chk("flush_req", {31'h0, imem_req_o}, 32'h1);
    chk("flush_addr", imem_addr_o, 32'h200);

    // PC wraps modulo 2^32
    redirect(2'b01, 32'h0, 32'hFFFF_FFF8);
    fetch_one("wrap", 32'hFFFF_FFFC, 32'h0, 32'h0000_0FFC, 1'b0, 32'h0, 1'b0);
    consume();
    chk("wrap_addr", imem_addr_o, 32'h0);

    // Encoding 11 behaves as 10
    redirect(2'b11, 32'h80, 32'h500);
    chk("wp11_addr", imem_addr_o, 32'h80);

    // Reset mid-transaction
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("midrst_pc", pc_o, 32'h0);
    chk("midrst_req", {31'h0, imem_req_o}, 32'h0);
    step();
    rst_ni = 1'b1;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h5555_6666;
    step();
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    chk("postrst_valid", {31'h0, id_valid_o}, 32'h0);
    chk("postrst_req", {31'h0, imem_req_o}, 32'h1);
    chk("postrst_addr", imem_addr_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
